// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
//
// Purpose:
//   Controller that owns a shared 16-bit combinational Hack-style ALU that
//   lives outside this block. ADD and SUB take one ALU pass. MUL
//   (shift-and-add) and DIV (restoring) each take 16 ALU passes. One command
//   is accepted at a time. The result is held on the response channel until
//   the consumer takes it.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; cmd_ready is high only in IDLE
//   cmd_op                00 MUL, 01 DIV, 10 ADD, 11 SUB
//   cmd_a, cmd_b          operands
//   rsp_valid/rsp_ready   response handshake; the response is held until taken
//   rsp_result, rsp_aux   result and auxiliary word (DIV remainder / error cmd_a)
//   rsp_zr, rsp_ng        zero and negative flags of rsp_result
//   rsp_err               DIV error (zero divisor or an operand with bit 15 set)
//   alu_x, alu_y          ALU operands driven by this block
//   alu_zx..alu_no, alu_f ALU controls driven by this block
//   alu_out, alu_zr/ng    ALU result and flags read back
// ---------------------------------------------------------------------------
module alu_op_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [WIDTH-1:0] rsp_aux,
  output logic             rsp_zr,
  output logic             rsp_ng,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic             alu_zx,
  output logic             alu_zy,
  output logic             alu_nx,
  output logic             alu_ny,
  output logic             alu_no,
  output logic [1:0]       alu_f,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zr,
  input  logic             alu_ng
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_MUL = 2'b00,
    OP_DIV = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } op_t;

  localparam logic [1:0] F_ADD = 2'b00;
  localparam logic [1:0] F_SUB = 2'b01;

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  // a_q: ADD/SUB minuend, MUL shifting multiplicand m, DIV shifting quotient q.
  // b_q: ADD/SUB subtrahend, MUL shifting multiplier n, DIV fixed divisor.
  // acc_q: MUL accumulator, DIV partial remainder r.
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rspResult_q, rspResult_d;
  logic [WIDTH-1:0] rspAux_q, rspAux_d;
  logic             rspZr_q, rspZr_d;
  logic             rspNg_q, rspNg_d;
  logic             rspErr_q, rspErr_d;

  logic [WIDTH-1:0] divShift;
  logic [WIDTH-1:0] mulAcc;
  logic [WIDTH-1:0] divRem;
  logic [WIDTH-1:0] divQuo;
  logic             divBad;

  // Restoring division shifts the next dividend bit into the remainder
  // before the trial subtraction.
  assign divShift = {acc_q[WIDTH-2:0], a_q[WIDTH-1]};

  // Division is defined only for non-negative operands and a non-zero divisor.
  assign divBad = (cmd_b == '0) || cmd_a[WIDTH-1] || cmd_b[WIDTH-1];

  assign rsp_result = rspResult_q;
  assign rsp_aux    = rspAux_q;
  assign rsp_zr     = rspZr_q;
  assign rsp_ng     = rspNg_q;
  assign rsp_err    = rspErr_q;

  // Next-state and output logic. Outside EXEC the ALU sees all-zero operands
  // and controls. The response registers change only when an operation
  // completes, so they keep their last values after the transfer. On the
  // final MUL/DIV pass, the freshly computed value goes straight into the
  // response registers. Its flags are derived from that same value.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    rspResult_d = rspResult_q;
    rspAux_d    = rspAux_q;
    rspZr_d     = rspZr_q;
    rspNg_d     = rspNg_q;
    rspErr_d    = rspErr_q;
    cmd_ready   = 1'b0;
    rsp_valid   = 1'b0;
    alu_x       = '0;
    alu_y       = '0;
    alu_zx      = 1'b0;
    alu_zy      = 1'b0;
    alu_nx      = 1'b0;
    alu_ny      = 1'b0;
    alu_no      = 1'b0;
    alu_f       = F_ADD;
    mulAcc      = acc_q;
    divRem      = divShift;
    divQuo      = {a_q[WIDTH-2:0], 1'b0};

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d  = op_t'(cmd_op);
          a_d   = cmd_a;
          b_d   = cmd_b;
          acc_d = '0;
          cnt_d = '0;
          if (op_t'(cmd_op) == OP_DIV && divBad) begin
            rspResult_d = '1;
            rspAux_d    = cmd_a;
            rspZr_d     = 1'b0;
            rspNg_d     = 1'b1;
            rspErr_d    = 1'b1;
            state_d     = DONE;
          end else begin
            state_d = EXEC;
          end
        end
      end

      EXEC: begin
        case (op_q)
          OP_ADD, OP_SUB: begin
            alu_x       = a_q;
            alu_y       = b_q;
            alu_f       = (op_q == OP_SUB) ? F_SUB : F_ADD;
            rspResult_d = alu_out;
            rspAux_d    = '0;
            rspZr_d     = alu_zr;
            rspNg_d     = alu_ng;
            rspErr_d    = 1'b0;
            state_d     = DONE;
          end

          OP_MUL: begin
            alu_x  = acc_q;
            alu_y  = a_q;
            alu_f  = F_ADD;
            mulAcc = b_q[0] ? alu_out : acc_q;
            acc_d  = mulAcc;
            a_d    = a_q << 1;
            b_d    = b_q >> 1;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == LAST_ITER) begin
              rspResult_d = mulAcc;
              rspAux_d    = '0;
              rspZr_d     = (mulAcc == '0);
              rspNg_d     = mulAcc[WIDTH-1];
              rspErr_d    = 1'b0;
              state_d     = DONE;
            end
          end

          default: begin
            // Trial subtraction: a non-negative ALU result means the
            // divisor fits, so keep the difference and set a quotient bit.
            alu_x = divShift;
            alu_y = b_q;
            alu_f = F_SUB;
            if (!alu_ng) begin
              divRem = alu_out;
              divQuo = {a_q[WIDTH-2:0], 1'b1};
            end
            acc_d = divRem;
            a_d   = divQuo;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ITER) begin
              rspResult_d = divQuo;
              rspAux_d    = divRem;
              rspZr_d     = (divQuo == '0);
              rspNg_d     = divQuo[WIDTH-1];
              rspErr_d    = 1'b0;
              state_d     = DONE;
            end
          end
        endcase
      end

      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset discards any operation in progress
  // and clears the response, so no response is issued for it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= OP_MUL;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      rspResult_q <= '0;
      rspAux_q    <= '0;
      rspZr_q     <= 1'b0;
      rspNg_q     <= 1'b0;
      rspErr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      rspResult_q <= rspResult_d;
      rspAux_q    <= rspAux_d;
      rspZr_q     <= rspZr_d;
      rspNg_q     <= rspNg_d;
      rspErr_q    <= rspErr_d;
    end
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Controller that owns the shared 16-bit combinational Hack-style ALU (inputs x,y; controls zx,zy,nx,ny,no,f[1:0]; outputs out,zr,ng) and sequences it to run single-cycle and multi-cycle operations. Accepts one command over a valid/ready request channel and returns one result over a valid/ready response channel. Multiply and divide are built as 16 iterations of ALU add/subtract. The ALU itself is instantiated outside this block; this block drives its inputs and reads its outputs.

Parameters:
WIDTH, 16, datapath width; equals ALU width; only 16 is supported and verified.

Ports:
clk  in  1  clock, all state updates on rising edge.
rst  in  1  asynchronous, active-high reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  block can accept a command; high only in IDLE.
cmd_op  in  2  00 MUL, 01 DIV, 10 ADD, 11 SUB.
cmd_a  in  16  operand A (multiplicand/dividend/minuend).
cmd_b  in  16  operand B (multiplier/divisor/subtrahend).
rsp_valid  out  1  response held valid until taken.
rsp_ready  in  1  consumer takes response.
rsp_result  out  16  MUL: product[15:0]; DIV: quotient; ADD/SUB: ALU out.
rsp_aux  out  16  DIV: remainder; error: cmd_a; otherwise 0.
rsp_zr  out  1  rsp_result == 0.
rsp_ng  out  1  rsp_result[15].
rsp_err  out  1  DIV error (divisor 0, or either operand bit15 set).
alu_x, alu_y  out  16  ALU operands.
alu_zx, alu_zy, alu_nx, alu_ny, alu_no  out  1  ALU controls.
alu_f  out  2  ALU function.
alu_out  in  16  ALU result.
alu_zr, alu_ng  in  1  ALU flags.

Behaviour:
- Reset (async, any state): state IDLE, cmd_ready=1, rsp_valid=0, rsp_result/rsp_aux=0, rsp_zr/rsp_ng/rsp_err=0, iteration counter 0, internal regs 0. An operation in progress is discarded and no response is issued.
- FSM states are IDLE, EXEC, DONE.
  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready at edge T, latch op/a/b and clear counter.
    - DIV with b==0, a[15] or b[15] set: go DONE. rsp_err=1, rsp_result=16'hFFFF, rsp_aux=a. rsp_valid is high at T+1.
    - Otherwise go EXEC.
  - EXEC:
    - ADD/SUB: one cycle.
    - MUL/DIV: exactly 16 cycles, counter 0..15. No early termination.
    - After the last EXEC cycle, go DONE with results registered.
  - DONE: rsp_valid=1, all rsp_* stable. Transfer occurs on rsp_valid&rsp_ready. The FSM then goes to IDLE; rsp_valid drops next cycle and rsp_* keep their last values. A new command is accepted no earlier than the cycle after the transfer.
- Latency from accept edge T to first cycle rsp_valid=1: ADD/SUB T+2, MUL/DIV T+17, DIV error T+1.
- ALU drive outside EXEC: alu_x=alu_y=0, all controls 0, alu_f=00.
- ADD: x=a, y=b, f=00, all zx..no=0. SUB: same with f=01. rsp_result=alu_out, rsp_zr=alu_zr, rsp_ng=alu_ng.
- MUL: registers acc=0, m=a, n=b.
  - Each EXEC cycle: x=acc, y=m, f=00, controls 0.
  - If n[0], acc<=alu_out. Then m<=m<<1 and n<=n>>1.
  - Result is acc modulo 2^16 with unsigned wrap. rsp_aux=0.
- DIV (restoring; operands 0..32767): registers q=a, r=0.
  - Each EXEC cycle: r'={r[14:0],q[15]}, x=r', y=b, f=01, controls 0.
  - If alu_ng==0: r<=alu_out and q<={q[14:0],1}.
  - Otherwise: r<=r' and q<={q[14:0],0}.
  - Result rsp_result=q, rsp_aux=r.
- rsp_zr and rsp_ng for MUL/DIV/error are computed from the registered rsp_result.
- cmd_valid while not IDLE is ignored (cmd_ready=0). The command must be held by the sender.
- rsp_ready while not DONE has no effect.

Test Plan:
- ADD a=0x7FFF, b=0x0001 -> rsp_valid at T+2, result 0x8000, ng=1, zr=0, err=0. SUB a=5, b=5 -> result 0, zr=1.
- MUL a=1000, b=100 -> rsp_valid exactly at T+17, result 0x86A0, aux 0. MUL a=0xFFFF, b=0xFFFF -> result 0x0001.
- DIV a=1000, b=7 -> result 142, aux 6, err=0 at T+17. DIV a=32767, b=1 -> result 32767, aux 0.
- DIV a=10, b=0 -> T+1 rsp_valid, err=1, result 0xFFFF, aux 10. DIV a=0x8000, b=3 -> err=1.
- Backpressure: rsp_ready low 5 cycles after rsp_valid -> outputs stable, cmd_ready=0, a new cmd_valid is not accepted. Raise rsp_ready -> IDLE next cycle, then back-to-back ADD accepted.
- Assert rst at EXEC counter=7 of MUL -> outputs immediately at reset values, no response. A subsequent MUL 3*4 returns 12.
